vga_scanout: RTL

Parametrised VGA scan-out engine: generates programmable sync/blank timing, issues framebuffer read addresses with tear-free scroll offsets and power-of-two pixel replication, and realigns returned pixel data to the sync stream across a configurable memory read latency. Sits between the dual-port framebuffer read port and the DAC pins. It replaces the fixed-640x480 timing-plus-drawer pair and runs directly on the pixel clock; clock generation is outside the block.

---
 rtl/vga_scanout.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_scanout.sv
// vga_scanout: programmable VGA sync/blank timing, scrolled and pixel-replicated
// framebuffer addressing, and colour output realigned to the sync stream
// across the framebuffer read latency. Runs entirely on the pixel clock.
module vga_scanout #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int IMG_W_LOG2 = 8,
    parameter int IMG_H_LOG2 = 8,
    parameter int ADDR_W     = 19,
    parameter int MEM_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            q_b,
    input  logic [IMG_W_LOG2-1:0] h_offset,
    input  logic [IMG_H_LOG2-1:0] v_offset,
    input  logic [1:0]            scale,
    input  logic                  mode,
    input  logic [7:0]            border,
    output logic [ADDR_W-1:0]     address_b,
    output logic                  vga_hsync,
    output logic                  vga_vsync,
    output logic                  sync_blank,
    output logic                  sync_b,
    output logic [7:0]            red,
    output logic [7:0]            green,
    output logic [7:0]            blue,
    output logic                  frame_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W  = $clog2(H_TOT);
    localparam int VC_W  = $clog2(V_TOT);

    localparam logic [31:0] H_ACT_C  = 32'(H_ACTIVE);
    localparam logic [31:0] V_ACT_C  = 32'(V_ACTIVE);
    localparam logic [31:0] H_LAST_C = 32'(H_TOT - 1);
    localparam logic [31:0] V_LAST_C = 32'(V_TOT - 1);
    localparam logic [31:0] HS_BEG_C = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] HS_END_C = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] VS_BEG_C = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] VS_END_C = 32'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [31:0] IMG_W_C  = 32'(1) << IMG_W_LOG2;
    localparam logic [31:0] IMG_H_C  = 32'(1) << IMG_H_LOG2;

    // Per-pixel attributes that travel alongside the memory read.
    typedef struct packed {
        logic active;
        logic in_window;
        logic hs_on;      // sync asserted (polarity applied at the pins)
        logic vs_on;
        logic mode;
        logic first;      // hc==0 && vc==0
    } tag_t;

    logic [HC_W-1:0]       hc;
    logic [VC_W-1:0]       vc;
    logic [31:0]           hc32;
    logic [31:0]           vc32;
    logic                  h_last;
    logic                  v_last;

    logic [IMG_W_LOG2-1:0] sh_h;
    logic [IMG_H_LOG2-1:0] sh_v;
    logic [1:0]            sh_scale;
    logic                  sh_mode;

    logic [31:0]           win_w;
    logic [31:0]           win_h;
    logic [31:0]           hx;
    logic [31:0]           vy;
    logic [IMG_W_LOG2-1:0] ix;
    logic [IMG_H_LOG2-1:0] iy;
    tag_t                  s0;

    tag_t                  pipe [MEM_LAT+1];
    tag_t                  tl;

    assign hc32   = 32'(hc);
    assign vc32   = 32'(vc);
    assign h_last = (hc32 == H_LAST_C);
    assign v_last = (vc32 == V_LAST_C);
    assign sync_b = 1'b0;

    // RGB332 expands each field by bit repetition; grayscale copies to all three.
    function automatic logic [23:0] decode(input logic [7:0] v, input logic rgb332);
        if (rgb332) begin
            return {v[7:5], v[7:5], v[7:6], v[4:2], v[4:2], v[4:3], {4{v[1:0]}}};
        end
        return {v, v, v};
    endfunction

    // Free-running pixel and line counters; frame period is fixed by the timing parameters.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register update uses <= so all flops sample pre-edge values together.
        if (!rst_n) begin
            hc <= '0;
            vc <= '0;
        end else if (h_last) begin
            hc <= '0;
            vc <= v_last ? '0 : vc + VC_W'(1);
        end else begin
            hc <= hc + HC_W'(1);
        end
    end

    // Scroll/scale/mode shadows reload only at the last pixel of a frame, so a frame never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_h     <= '0;
            sh_v     <= '0;
            sh_scale <= '0;
            sh_mode  <= 1'b0;
        end else if (h_last && v_last) begin
            sh_h     <= h_offset;
            sh_v     <= v_offset;
            sh_scale <= (scale == 2'd3) ? 2'd2 : scale;
            sh_mode  <= mode;
        end
    end

    // Stage 0: timing flags, image window test and wrapped image coordinates.
    always_comb begin
        // NOTE: everything gets a default before any condition, so no latch can be inferred.
        s0    = '0;
        win_w = IMG_W_C << sh_scale;
        win_h = IMG_H_C << sh_scale;
        hx    = hc32 >> sh_scale;
        vy    = vc32 >> sh_scale;
        ix    = IMG_W_LOG2'(hx + 32'(sh_h));
        iy    = IMG_H_LOG2'(vy + 32'(sh_v));

        s0.active    = (hc32 < H_ACT_C) && (vc32 < V_ACT_C);
        s0.in_window = (hc32 < win_w) && (vc32 < win_h);
        s0.hs_on     = (hc32 >= HS_BEG_C) && (hc32 < HS_END_C);
        s0.vs_on     = (vc32 >= VS_BEG_C) && (vc32 < VS_END_C);
        s0.mode      = sh_mode;
        s0.first     = (hc32 == 32'd0) && (vc32 == 32'd0);
    end

    // Read address is issued only for visible in-window pixels and otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            address_b <= '0;
        end else if (s0.active && s0.in_window) begin
            address_b <= ADDR_W'({iy, ix});
        end
    end

    // Delay line matching the address register plus memory latency.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the delay line is only a few flops wide, so it is reset; cleared entries
        // mean "blanked, no sync", which keeps the pins quiet until real timing arrives.
        if (!rst_n) begin
            for (int i = 0; i <= MEM_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= s0;
            for (int i = 1; i <= MEM_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign tl = pipe[MEM_LAT];

    // Output register: sync, blank and colour leave together, MEM_LAT+2 after stage 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_hsync   <= 1'b1;
            vga_vsync   <= 1'b1;
            sync_blank  <= 1'b0;
            frame_start <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
        end else begin
            vga_hsync   <= ~tl.hs_on;
            vga_vsync   <= ~tl.vs_on;
            sync_blank  <= tl.active;
            frame_start <= tl.first;
            if (!tl.active) begin
                {red, green, blue} <= '0;
            end else if (!tl.in_window) begin
                {red, green, blue} <= decode(border, tl.mode);
            end else begin
                {red, green, blue} <= decode(q_b, tl.mode);
            end
        end
    end

endmodule
